// File: rtl/ieee488_host_xfer.sv
// rtl/ieee488_host_xfer.sv - controller-side IEEE-488 byte engine (source and acceptor roles)
// Optional feature macro: IEEE488_HOST_TIMEOUT_EN enables the wait-state timeout abort (err=10).
module ieee488_host_xfer #(
    parameter int SETTLE_TICKS  = 2,
    parameter int TIMEOUT_TICKS = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] ieee_data_i,
    input  logic       ieee_dav_i,
    input  logic       ieee_eoi_i,
    input  logic       ieee_nrfd_i,
    input  logic       ieee_ndac_i,
    input  logic       ieee_ifc_i,
    output logic [7:0] ieee_data_o,
    output logic       ieee_dav_o,
    output logic       ieee_eoi_o,
    output logic       ieee_atn_o,
    output logic       ieee_nrfd_o,
    output logic       ieee_ndac_o,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_eoi,
    input  logic       tx_atn,
    input  logic       atn_release,
    output logic       tx_done,
    input  logic       rx_en,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_eoi,
    output logic       busy,
    output logic [1:0] err
);
    typedef enum logic [2:0] {IDLE, T_CHK, T_RFD, T_SETTLE, T_DAC, L_NRDY, L_DAV, L_DAVREL} state_t;

    if (SETTLE_TICKS < 1 || SETTLE_TICKS > 255 || TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 16777215) begin : g_param_check
        $error("ieee488_host_xfer: parameter out of range");
    end

    logic [12:0] sync1, sync2;
    logic [7:0]  data_s;
    logic        dav_s, eoi_s, nrfd_s, ndac_s, ifc_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {ieee_ifc_i, ieee_ndac_i, ieee_nrfd_i, ieee_eoi_i, ieee_dav_i, ieee_data_i};
            sync2 <= sync1;
        end
    end
    assign {ifc_s, ndac_s, nrfd_s, eoi_s, dav_s, data_s} = sync2;

    state_t     state, state_d;
    logic [7:0] data_d, rxd_d, settle_cnt, settle_d;
    logic       dav_d, eoi_d, atn_d, nrfd_d, ndac_d, done_d, rxv_d, rxe_d;
    logic [1:0] err_d;
    logic       timed_out;

`ifdef IEEE488_HOST_TIMEOUT_EN
    logic [23:0] to_cnt;
    logic        timed_state;
    assign timed_state = (state == T_RFD) || (state == T_DAC) || (state == L_DAVREL);
    assign timed_out   = timed_state && ce && (to_cnt == 24'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset || (state_d != state))
            to_cnt <= '0;
        else if (timed_state && ce)
            to_cnt <= to_cnt + 24'd1;
    end
`else
    assign timed_out = 1'b0;
`endif

    // A byte is only offered to the host when neither the acceptor role nor an IFC abort can claim the cycle.
    assign tx_ready = (state == IDLE) && !rx_en && !rx_valid && !ifc_s;
    assign busy     = (state != IDLE);

    always_comb begin
        state_d  = state;
        data_d   = ieee_data_o;
        dav_d    = ieee_dav_o;
        eoi_d    = ieee_eoi_o;
        atn_d    = ieee_atn_o;
        nrfd_d   = ieee_nrfd_o;
        ndac_d   = ieee_ndac_o;
        done_d   = 1'b0;
        rxv_d    = rx_valid;
        rxd_d    = rx_data;
        rxe_d    = rx_eoi;
        err_d    = err;
        settle_d = settle_cnt;
        if (rx_valid && rx_ready) rxv_d = 1'b0;
        if (ifc_s) begin
            state_d = IDLE;
            {data_d, dav_d, eoi_d, atn_d, nrfd_d, ndac_d} = '0;
            err_d   = 2'b11;
        end else if (timed_out) begin
            state_d = IDLE;
            {data_d, dav_d, eoi_d, nrfd_d, ndac_d} = '0;
            err_d   = 2'b10;
        end else begin
            case (state)
                IDLE: begin
                    if (atn_release) atn_d = 1'b0;
                    if (tx_valid && tx_ready) begin
                        data_d  = tx_data;
                        eoi_d   = tx_eoi;
                        atn_d   = tx_atn;
                        err_d   = 2'b00;
                        state_d = T_CHK;
                    end else if (rx_en) begin
                        nrfd_d  = 1'b1;
                        ndac_d  = 1'b1;
                        state_d = L_NRDY;
                    end
                end
                T_CHK: begin
                    // Both handshake lines released means no listener is on the bus.
                    if (!nrfd_s && !ndac_s) begin
                        err_d   = 2'b01;
                        data_d  = '0;
                        eoi_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = T_RFD;
                    end
                end
                T_RFD: begin
                    if (!nrfd_s) begin
                        settle_d = 8'(SETTLE_TICKS);
                        state_d  = T_SETTLE;
                    end
                end
                T_SETTLE: begin
                    if (ce) begin
                        settle_d = settle_cnt - 8'd1;
                        if (settle_cnt <= 8'd1) begin
                            dav_d   = 1'b1;
                            state_d = T_DAC;
                        end
                    end
                end
                T_DAC: begin
                    if (!ndac_s) begin
                        {data_d, dav_d, eoi_d} = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                L_NRDY: begin
                    nrfd_d = 1'b1;
                    ndac_d = 1'b1;
                    if (!rx_en) begin
                        {nrfd_d, ndac_d} = '0;
                        state_d = IDLE;
                    end else if (!rx_valid) begin
                        nrfd_d  = 1'b0;
                        state_d = L_DAV;
                    end
                end
                L_DAV: begin
                    if (!rx_en) begin
                        {nrfd_d, ndac_d} = '0;
                        state_d = IDLE;
                    end else if (dav_s) begin
                        nrfd_d  = 1'b1;
                        rxd_d   = data_s;
                        rxe_d   = eoi_s;
                        ndac_d  = 1'b0;
                        rxv_d   = 1'b1;
                        state_d = L_DAVREL;
                    end
                end
                L_DAVREL: begin
                    if (!dav_s) begin
                        if (rx_en) begin
                            ndac_d  = 1'b1;
                            state_d = L_NRDY;
                        end else begin
                            {nrfd_d, ndac_d} = '0;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ieee_data_o <= '0;
            ieee_dav_o  <= 1'b0;
            ieee_eoi_o  <= 1'b0;
            ieee_atn_o  <= 1'b0;
            ieee_nrfd_o <= 1'b0;
            ieee_ndac_o <= 1'b0;
            tx_done     <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_eoi      <= 1'b0;
            err         <= 2'b00;
            settle_cnt  <= '0;
        end else begin
            state       <= state_d;
            ieee_data_o <= data_d;
            ieee_dav_o  <= dav_d;
            ieee_eoi_o  <= eoi_d;
            ieee_atn_o  <= atn_d;
            ieee_nrfd_o <= nrfd_d;
            ieee_ndac_o <= ndac_d;
            tx_done     <= done_d;
            rx_valid    <= rxv_d;
            rx_data     <= rxd_d;
            rx_eoi      <= rxe_d;
            err         <= err_d;
            settle_cnt  <= settle_d;
        end
    end
endmodule
